vm_change_dispenser: RTL

//  Downstream stage of vm: consumes vm's change[9:0] value (sen) and refund strobe, pays it out as

---
 rtl/vm_change_dispenser.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vm_change_dispenser.sv
// Change dispenser: greedy largest-first payout over {100,50,20,10,5} through a pulsed ejector
// with per-item ack, inventory tracking, jam detection. Optional audit counter: VM_CHANGE_AUDIT_EN.
module vm_change_dispenser #(
  parameter int INV_WIDTH   = 8,
  parameter int INV_INIT    = 50,
  parameter int LOW_THRESH  = 5,
  parameter int PULSE_LEN   = 4,
  parameter int ACK_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  change,
  input  logic        refund,
  input  logic        maintenance,
  input  logic        refill,
  input  logic        eject_ack,
  output logic [4:0]  eject,
  output logic        busy,
  output logic        done,
  output logic [9:0]  shortfall,
  output logic        jam,
  output logic [4:0]  low_stock
`ifdef VM_CHANGE_AUDIT_EN
  ,
  output logic [15:0] audit_total
`endif
);
  localparam int CNT_W = $clog2((ACK_TIMEOUT > PULSE_LEN) ? ACK_TIMEOUT : PULSE_LEN) + 1;
  localparam logic [4:0][9:0] DENOM = {10'd100, 10'd50, 10'd20, 10'd10, 10'd5};
  localparam logic [4:0][INV_WIDTH-1:0] INV_FULL = {5{INV_WIDTH'(INV_INIT)}};

  typedef enum logic [2:0] {IDLE, PICK, FIRE, WAIT, DONE} state_t;

  state_t                    state, state_n;
  logic [9:0]                rem;
  logic [2:0]                sel, pick_idx;
  logic                      pick_ok;
  logic [CNT_W-1:0]          cnt;
  logic [4:0][INV_WIDTH-1:0] inv;

  wire start   = (state == IDLE) && refund && !maintenance;
  wire pul_end = (cnt == CNT_W'(PULSE_LEN - 1));
  wire ack_to  = (cnt == CNT_W'(ACK_TIMEOUT - 1));

  // ascending scan, last hit wins -> largest payable denomination in stock
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = 3'd0;
    for (int i = 0; i < 5; i++)
      if (DENOM[i] <= rem && inv[i] != '0) begin
        pick_ok  = 1'b1;
        pick_idx = 3'(i);
      end
  end

  genvar g;
  generate
    for (g = 0; g < 5; g++) begin : g_low
      assign low_stock[g] = (inv[g] < INV_WIDTH'(LOW_THRESH));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    eject   = 5'b0;
    busy    = (state != IDLE);
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = PICK;
      PICK: state_n = pick_ok ? FIRE : DONE;
      FIRE: begin
        eject = 5'b1 << sel;
        if (pul_end) state_n = WAIT;
      end
      WAIT: begin
        if (eject_ack)   state_n = PICK;
        else if (ack_to) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      sel       <= '0;
      cnt       <= '0;
      inv       <= INV_FULL;
      shortfall <= '0;
      jam       <= 1'b0;
`ifdef VM_CHANGE_AUDIT_EN
      audit_total <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem       <= change;
            shortfall <= '0;
          end else if (refill && maintenance) begin
            inv <= INV_FULL;
            jam <= 1'b0;
          end
        end
        PICK: begin
          cnt <= '0;
          if (pick_ok) begin
            inv[pick_idx] <= inv[pick_idx] - INV_WIDTH'(1);
            rem           <= rem - DENOM[pick_idx];
            sel           <= pick_idx;
          end else begin
            shortfall <= rem;
          end
        end
        FIRE: cnt <= pul_end ? '0 : cnt + CNT_W'(1);
        WAIT: begin
          if (eject_ack) begin
`ifdef VM_CHANGE_AUDIT_EN
            audit_total <= audit_total + 16'(DENOM[sel]);
`endif
          end else if (ack_to) begin
            // the jammed item never left; it is owed but its inventory is gone
            jam       <= 1'b1;
            shortfall <= rem + DENOM[sel];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
